// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants, frame defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_receiver_pkg;

  // Receiver frame-tracking states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // 16x oversampling: tick 7 is the middle of the start bit, tick 15 ends a bit period
  localparam int MID_TICK  = 7;
  localparam int LAST_TICK = 15;

  // Frame format defaults shared with the transmitter (8 data bits, 1 stop bit)
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset value selectable.
// Latency: 2 clk from input change to output change.
// Backpressure: none; free-running.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops to resolve metastability on the async input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: 16x-oversampled start detect, mid-bit data sampling, LSB first.
// Latency: 2 clk sync + 8 + 16*DBIT + SB_TICK s_tick pulses from start edge to rx_done_tick.
// Backpressure: none; each byte is presented once with a single-cycle done pulse.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout
);

  // Tick counter must reach both the bit period (15) and the stop length minus one
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  rx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            rx_s;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  // Frame FSM; counters only advance on s_tick, and a transition consumes its tick
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(MID_TICK)) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went back high before mid start bit: a glitch, not a frame
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == SW'(LAST_TICK)) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            // Stop level is not checked; the byte is delivered regardless
            state_d = IDLE;
            dout_d  = b_q;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized and directed bench for uart_receiver against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       s_tick;
  logic       rx_done_tick;
  logic [7:0] dout;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int pulse_cnt = 0;
  int exp_total = 0;

  // Reference model: bytes that must be delivered, in order, and the byte dout must hold
  logic [7:0] exp_q[$];
  logic [7:0] model_dout;
  logic       prev_done;

  event tick_ev;

  uart_receiver #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Baud generator stand-in: one-clk s_tick every 16 clk
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (15) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
      ->tick_ev;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(tick_ev);
  endtask

  task automatic send_bit(input logic v, input int nticks);
    rx = v;
    wait_ticks(nticks);
  endtask

  // Full 8N1 frame; the model expects this byte to be delivered
  task automatic send_frame(input logic [7:0] data);
    exp_q.push_back(data);
    exp_total++;
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(data[i], 16);
    send_bit(1'b1, 16);
  endtask

  // Every completed frame must already have produced its pulse by end of stop bit
  task automatic frame_check(input string tag);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_dout"}, dout, model_dout);
  endtask

  // Monitor: each pulse is one cycle wide and carries the next expected byte
  always @(negedge clk) begin
    if (reset && rx_done_tick) begin
      pulse_cnt++;
      chk("pulse_width", prev_done, 1'b0);
      chk("pulse_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        model_dout = exp_q.pop_front();
        chk("pulse_dout", dout, model_dout);
      end
    end
    prev_done = rx_done_tick;
  end

  initial begin
    #900us;
    $display("FAIL timeout: simulation did not complete, got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    int         p0;
    model_dout = 8'h00;
    prev_done  = 1'b0;
    rx    = 1'b1;
    reset = 1'b0;

    // Reset held with the line toggling: outputs stay cleared
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx = 1'($urandom_range(0, 1));
      if (i % 8 == 7) begin
        chk("rst_dout", dout, 8'h00);
        chk("rst_done", rx_done_tick, 1'b0);
      end
    end
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    wait_ticks(12);
    chk("post_rst_pulses", pulse_cnt, 0);
    chk("post_rst_dout", dout, 8'h00);

    // Single frame and LSB-first ordering
    send_frame(8'h55);
    frame_check("f55");
    wait_ticks(3);
    send_frame(8'hA3);
    frame_check("fA3");
    wait_ticks(3);

    // False start: 4 ticks low then back high
    p0 = pulse_cnt;
    send_bit(1'b0, 4);
    send_bit(1'b1, 30);
    chk("false_start_pulses", pulse_cnt, p0);
    chk("false_start_dout", dout, 8'hA3);

    // Back-to-back frames, no idle gap
    send_frame(8'h0F);
    frame_check("b2b_0F");
    send_frame(8'hF0);
    frame_check("b2b_F0");
    wait_ticks(2);

    // Mid-frame reset during 4th data bit of 0xFF
    p0 = pulse_cnt;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    @(negedge clk);
    reset = 1'b0;
    model_dout = 8'h00;
    @(negedge clk);
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_done", rx_done_tick, 1'b0);
    rx = 1'b1;
    wait_ticks(1);
    @(negedge clk);
    reset = 1'b1;
    wait_ticks(4);
    chk("midrst_pulses", pulse_cnt, p0);
    send_frame(8'h3C);
    frame_check("after_rst_3C");
    wait_ticks(2);

    // Random bytes with random idle gaps (including none)
    for (int k = 0; k < 14; k++) begin
      rb = 8'($urandom);
      send_frame(rb);
      frame_check("rand");
      wait_ticks($urandom_range(0, 4));
    end

    wait_ticks(4);
    chk("total_pulses", pulse_cnt, exp_total);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive path: samples the asynchronous `rx` line using an external 16x-oversampling tick (`s_tick`) and recovers 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit). Each complete byte appears on `dout` together with a one-cycle `rx_done_tick`. The block sits between the board-level serial input and the keyboard/monitor datapath, with `s_tick` supplied by the shared baud-rate generator.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame; also the width of `dout`.
- `SB_TICK`, 16: `s_tick` count spanning the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `s_tick`  in  1  sampling enable, 16 pulses per bit period, one `clk` wide each.
- `rx_done_tick`  out  1  one-cycle pulse when a frame completes.
- `dout`  out  DBIT  last received byte.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1 (idle). All decisions below use the synchronized value `rx_s`.
- Registers:
  - state ∈ {IDLE, START, DATA, STOP}
  - tick counter `s` (4 bits, or wide enough for `SB_TICK-1`)
  - bit counter `n` (log2 DBIT bits)
  - shift register `b` (DBIT bits)
- IDLE: if `rx_s`==0, go to START and clear `s`. No `s_tick` is needed.
- START: counts only on cycles where `s_tick`=1.
  - At `s`==7 (mid start bit): if `rx_s`==0, go to DATA with `s`=0 and `n`=0.
  - At `s`==7 with `rx_s`==1: treat as a glitch and return to IDLE without a done pulse.
  - Otherwise `s` increments.
- DATA: on `s_tick`:
  - At `s`==15: clear `s` and shift `b` <= {`rx_s`, `b[DBIT-1:1]`}, so the LSB arrives first.
  - If `n`==DBIT-1, go to STOP; otherwise increment `n`.
  - Otherwise `s` increments.
- STOP: on `s_tick`:
  - At `s`==SB_TICK-1: return to IDLE, load `dout` <= `b`, and pulse `rx_done_tick`.
  - Otherwise `s` increments.
  - The stop-bit level is not checked; there is no framing-error output.
- `dout` changes only when `rx_done_tick` fires and holds its value between frames.
- Counters hold when `s_tick`=0. `s_tick` is ignored in IDLE.

## Timing
- Reset values: state IDLE, `s`=0, `n`=0, `b`=0, `dout`=0, `rx_done_tick`=0, synchronizer flops 1.
- `rx_done_tick` and `dout` are registered. The pulse is high for exactly one `clk` cycle, in the same cycle `dout` first shows the new byte.
- Latency: about 2 `clk` for the synchronizer plus, counted in `s_tick` pulses after the start edge, 8 + 16·DBIT + SB_TICK pulses until the done pulse (152 with defaults).
- Data bits are sampled mid-bit, 16 ticks apart.
- Back-to-back frames: a start edge seen in the cycle after STOP→IDLE is accepted. No idle gap is required beyond the stop bit.
- Reset asserted mid-frame aborts the frame immediately: no pulse, `dout` cleared.
- `s_tick` active on the same cycle as a state transition: the transition consumes that tick.

## Structure
- Shared package holds:
  - the state enum (IDLE, START, DATA, STOP)
  - mid-bit constant 7 and bit-period constant 15
  - default `DBIT`/`SB_TICK` constants, which the transmitter also uses
- One sub-module: `sync_2ff`, a parameterizable-reset-value two-flop synchronizer for `rx`.
- Everything else is one FSM with next-state logic in a single process.

## Test plan
- Reset: hold `reset`=0 with `rx` toggling. Required: `dout`=0x00 and `rx_done_tick`=0 throughout. After release with `rx`=1, no pulse occurs.
- Single frame: `s_tick` every 16 `clk`, send 0x55 (line 0,1,0,1,0,1,0,1,0,1, 16 ticks per bit). Required: exactly one `rx_done_tick` pulse of one cycle, with `dout`=0x55.
- LSB order: send 0xA3. Required: `dout`=0xA3, not 0xC5.
- False start: drive `rx` low for 4 ticks, then high. Required: return to IDLE, no pulse, `dout` unchanged.
- Back-to-back: send 0x0F then 0xF0 with no idle gap. Required: two pulses, `dout`=0x0F then 0xF0.
- Mid-frame reset: assert `reset` during the 4th data bit of 0xFF, then send 0x3C. Required: no pulse for the aborted frame, and `dout`=0x3C after the second frame.
